// File: rtl/mem_pkg.sv
// Shared widths and word/address types for the FIR coefficient and sample storage.
package mem_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/mem_bank.sv
// One flop-based DEPTH x DATA_W bank with a single shared write/read address and registered read.
// Optional macro MEM_WR_BYPASS_EN forwards write data to dout on a same-cycle write.
module mem_bank
    import mem_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  we,
    input  addr_t addr,
    input  word_t din,
    output word_t dout
);

    word_t [DEPTH-1:0] mem;
    word_t             rdWord;

    // The read and write share one address, so every write is a same-address collision.
`ifdef MEM_WR_BYPASS_EN
    assign rdWord = we ? din : mem[addr];
`else
    assign rdWord = mem[addr];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem  <= '0;
            dout <= '0;
        end else begin
            if (we) mem[addr] <= din;
            dout <= rdWord;
        end
    end

endmodule

// File: rtl/mem_top.sv
// Coefficient and sample storage feeding the FIR multiply-accumulate stage.
// Optional macro MEM_WR_BYPASS_EN selects write-through forwarding in both banks.
module mem_top
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              cload,
    input  logic [ADDR_W-1:0] caddr,
    input  logic [DATA_W-1:0] cin,
    input  logic              xload,
    input  logic [ADDR_W-1:0] xaddr,
    input  logic [DATA_W-1:0] xin,
    output logic [DATA_W-1:0] coeffCurr,
    output logic [DATA_W-1:0] xCurr
);

    mem_bank coeffBank (
        .clk  (clk),
        .rstn (rstn),
        .we   (cload),
        .addr (caddr),
        .din  (cin),
        .dout (coeffCurr)
    );

    mem_bank sampleBank (
        .clk  (clk),
        .rstn (rstn),
        .we   (xload),
        .addr (xaddr),
        .din  (xin),
        .dout (xCurr)
    );

endmodule

// File: tb/tb_mem_top.sv
// Scoreboard bench for mem_top: a reference copy of both banks predicts each registered read.
module tb_mem_top;
    import mem_pkg::*;

    logic  clk = 1'b0;
    logic  rstn;
    logic  cload, xload;
    addr_t caddr, xaddr;
    word_t cin, xin;
    word_t coeffCurr, xCurr;

    int nChecks = 0;
    int nFails  = 0;

    word_t cModel [DEPTH];
    word_t xModel [DEPTH];
    word_t expCq [$];
    word_t expXq [$];

    mem_top dut (
        .clk       (clk),
        .rstn      (rstn),
        .cload     (cload),
        .caddr     (caddr),
        .cin       (cin),
        .xload     (xload),
        .xaddr     (xaddr),
        .xin       (xin),
        .coeffCurr (coeffCurr),
        .xCurr     (xCurr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) begin
            cModel[i] = '0;
            xModel[i] = '0;
        end
    endtask

    // Drive one cycle at the falling edge, predict the registered reads, compare after the rising edge.
    task automatic cycle(input string tag, input logic cl, input addr_t ca, input word_t ci,
                         input logic xl, input addr_t xa, input word_t xi);
        word_t eC, eX;
        cload = cl; caddr = ca; cin = ci;
        xload = xl; xaddr = xa; xin = xi;
        eC = cModel[ca];
        eX = xModel[xa];
`ifdef MEM_WR_BYPASS_EN
        if (cl) eC = ci;
        if (xl) eX = xi;
`endif
        expCq.push_back(eC);
        expXq.push_back(eX);
        if (cl) cModel[ca] = ci;
        if (xl) xModel[xa] = xi;
        @(posedge clk);
        #1;
        chk({tag, "_c"}, coeffCurr, expCq.pop_front());
        chk({tag, "_x"}, xCurr, expXq.pop_front());
        @(negedge clk);
    endtask

    task automatic sweepZero(input string tag);
        for (int i = 0; i < DEPTH; i++)
            cycle(tag, 1'b0, addr_t'(i), '0, 1'b0, addr_t'(DEPTH - 1 - i), '0);
    endtask

    initial begin
        clearModel();
        rstn = 1'b0;
        cload = 1'b1; xload = 1'b1;
        caddr = 6'd3; xaddr = 6'd7;
        cin = 16'hFFFF; xin = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c", coeffCurr, 16'h0000);
        chk("rst_x", xCurr, 16'h0000);
        @(negedge clk);
        rstn = 1'b1;
        sweepZero("rstsweep");

        for (int i = 0; i < DEPTH; i++)
            cycle("cload", 1'b1, addr_t'(i), word_t'(16'h1000 + i), 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++)
            cycle("cread", 1'b0, addr_t'(i), '0, 1'b0, '0, '0);

        // Coefficients swept alongside the sample load to confirm bank independence.
        for (int i = 0; i < DEPTH; i++)
            cycle("xload", 1'b0, addr_t'(i), 16'hDEAD, 1'b1, addr_t'(i), word_t'(i));
        for (int i = 0; i < DEPTH; i++)
            cycle("xread", 1'b0, addr_t'(DEPTH - 1 - i), '0, 1'b0, addr_t'(i), '0);

        cycle("collA", 1'b1, 6'd5, 16'h00AA, 1'b0, 6'd5, '0);
        cycle("collB", 1'b1, 6'd5, 16'h0055, 1'b1, 6'd9, 16'h1234);
        cycle("collC", 1'b0, 6'd5, '0, 1'b0, 6'd9, '0);

        cycle("simul", 1'b1, 6'd63, 16'h7FFF, 1'b1, 6'd0, 16'h8000);
        cycle("simrd", 1'b0, 6'd63, '0, 1'b0, 6'd0, '0);

        cycle("prerst", 1'b0, 6'd1, '0, 1'b0, 6'd2, '0);
        chk("prerst_nz", word_t'(coeffCurr != 16'h0 && xCurr != 16'h0), 16'h0001);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_c", coeffCurr, 16'h0000);
        chk("arst_x", xCurr, 16'h0000);
        clearModel();
        @(negedge clk);
        rstn = 1'b1;
        sweepZero("postrst");

        if (expCq.size() != 0 || expXq.size() != 0)
            chk("sb_empty", word_t'(expCq.size() + expXq.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
